// File: rtl/addr_generator_if.sv
// Bus bundle for addr_generator: AG-stage operand inputs, MR-stage load control and address results.
// The slave modport is the generator's view; the master modport is the driving stage's view.
interface addr_generator_if;
  logic        e;
  logic        v_in;
  logic [31:0] dval;
  logic [31:0] sval;
  logic [31:0] disp;
  logic        rmsel;
  logic [7:0]  modrm;
  logic [15:0] sreg;
  logic        re;
  logic [2:0]  jmp;
  logic [31:0] addr_comb;
  logic [31:0] addr;
  logic        mem_acc;
  logic        v_out;

  modport slave (
    input  e, v_in, dval, sval, disp, rmsel, modrm, sreg, re, jmp,
    output addr_comb, addr, mem_acc, v_out
  );

  modport master (
    output e, v_in, dval, sval, disp, rmsel, modrm, sreg, re, jmp,
    input  addr_comb, addr, mem_acc, v_out
  );
endinterface

// File: rtl/addr_generator.sv
// ModRM effective/linear address generator with an MR-stage output register.
// Define ADDR_GEN_SEG_BASE_EN to add the segment base (sreg << SEG_SHIFT) to the offset.
module addr_generator #(
  parameter int unsigned SEG_SHIFT = 4
) (
  input  logic           clk,
  input  logic           r,
  addr_generator_if.slave bus
);

  logic [1:0]  mod_f;
  logic [2:0]  rm_f;
  logic [31:0] base;
  logic [31:0] disp8_sx;
  logic [31:0] offset;
  logic [31:0] lin_addr;
  logic        mem_acc_c;

  logic [31:0] addr_d, addr_q;
  logic        mem_acc_d, mem_acc_q;
  logic        v_out_d, v_out_q;

  always_comb begin
    mod_f    = bus.modrm[7:6];
    rm_f     = bus.modrm[2:0];
    base     = bus.rmsel ? bus.dval : bus.sval;
    disp8_sx = {{24{bus.disp[7]}}, bus.disp[7:0]};
    offset   = '0;
    case (mod_f)
      2'b00:   offset = (rm_f == 3'b101) ? bus.disp : base;
      2'b01:   offset = base + disp8_sx;
      2'b10:   offset = base + bus.disp;
      default: offset = '0;
    endcase
  end

`ifdef ADDR_GEN_SEG_BASE_EN
  logic [31:0] seg_base;
  assign seg_base = {16'h0000, bus.sreg} << SEG_SHIFT;
  assign lin_addr = offset + seg_base;
`else
  assign lin_addr = offset;
`endif

  // Register-direct operands (mod=11) never touch memory, even for reads or jumps.
  assign mem_acc_c = (bus.re | bus.jmp[2]) & (mod_f != 2'b11);

  always_comb begin
    addr_d    = addr_q;
    mem_acc_d = mem_acc_q;
    v_out_d   = v_out_q;
    if (bus.e) begin
      addr_d    = lin_addr;
      mem_acc_d = mem_acc_c;
      v_out_d   = bus.v_in;
    end
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      addr_q    <= '0;
      mem_acc_q <= 1'b0;
      v_out_q   <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      mem_acc_q <= mem_acc_d;
      v_out_q   <= v_out_d;
    end
  end

  assign bus.addr_comb = lin_addr;
  assign bus.addr      = addr_q;
  assign bus.mem_acc   = mem_acc_q;
  assign bus.v_out     = v_out_q;

  // The reg field and low jump bits carry no address information.
  logic unused_bits;
`ifdef ADDR_GEN_SEG_BASE_EN
  assign unused_bits = ^{bus.modrm[5:3], bus.jmp[1:0]};
`else
  assign unused_bits = ^{bus.modrm[5:3], bus.jmp[1:0], bus.sreg};
`endif

endmodule

// File: tb/tb_addr_generator.sv
// Directed testbench for addr_generator: reset, each ModRM addressing mode, wrap-around, stall and mid-run reset.
// Expected values are hand-computed for SEG_SHIFT=4, with or without ADDR_GEN_SEG_BASE_EN.
module tb_addr_generator;

  logic clk;
  logic r;
  int   check_cnt;
  int   pass_cnt;

  addr_generator_if bus_if ();

  addr_generator #(.SEG_SHIFT(4)) dut (
    .clk (clk),
    .r   (r),
    .bus (bus_if)
  );

`ifdef ADDR_GEN_SEG_BASE_EN
  localparam logic [31:0] ABS_EXP = 32'h12345778;
`else
  localparam logic [31:0] ABS_EXP = 32'h12345678;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // Drive one AG-stage instruction at the falling edge and let combinational logic settle.
  task automatic applyStimulus(input logic [7:0] modrm, input logic rmsel,
                               input logic [31:0] dval, input logic [31:0] sval,
                               input logic [31:0] disp, input logic [15:0] sreg,
                               input logic re, input logic [2:0] jmp);
    @(negedge clk);
    bus_if.modrm = modrm;
    bus_if.rmsel = rmsel;
    bus_if.dval  = dval;
    bus_if.sval  = sval;
    bus_if.disp  = disp;
    bus_if.sreg  = sreg;
    bus_if.re    = re;
    bus_if.jmp   = jmp;
    #1;
  endtask

  task automatic stepEdge;
    @(posedge clk);
    #1;
  endtask

  initial begin
    check_cnt = 0;
    pass_cnt  = 0;
    r = 1'b0;
    bus_if.e     = 1'b1;
    bus_if.v_in  = 1'b1;
    bus_if.modrm = 8'h00;
    bus_if.rmsel = 1'b1;
    bus_if.dval  = 32'hDEAD0000;
    bus_if.sval  = 32'h0;
    bus_if.disp  = 32'h0;
    bus_if.sreg  = 16'h0;
    bus_if.re    = 1'b1;
    bus_if.jmp   = 3'b000;

    // Reset held with e=1 and the clock running
    repeat (3) stepEdge();
    checkOutput("reset_addr", bus_if.addr, 32'h0);
    checkOutput("reset_mem_acc", {31'b0, bus_if.mem_acc}, 32'h0);
    checkOutput("reset_v_out", {31'b0, bus_if.v_out}, 32'h0);

    @(negedge clk);
    r = 1'b1;
    stepEdge();
    checkOutput("release_v_out", {31'b0, bus_if.v_out}, 32'h1);
    checkOutput("release_addr", bus_if.addr, 32'hDEAD0000);

    // mod=01 with negative disp8
    applyStimulus(8'b01_000_000, 1'b1, 32'h00001000, 32'h0, 32'h000000F0, 16'h0, 1'b1, 3'b000);
    checkOutput("disp8_neg_comb", bus_if.addr_comb, 32'h00000FF0);
    stepEdge();
    checkOutput("disp8_neg_addr", bus_if.addr, 32'h00000FF0);
    checkOutput("disp8_neg_mem_acc", {31'b0, bus_if.mem_acc}, 32'h1);

    // mod=01 positive disp8; upper disp bits must be ignored
    applyStimulus(8'b01_000_000, 1'b1, 32'h00000100, 32'h0, 32'hFFFFFF7F, 16'h0, 1'b1, 3'b000);
    checkOutput("disp8_pos_comb", bus_if.addr_comb, 32'h0000017F);

    // mod=00 rm=101 absolute displacement, segment applied only when enabled
    applyStimulus(8'b00_000_101, 1'b1, 32'hAAAA0000, 32'h0, 32'h12345678, 16'h0010, 1'b1, 3'b000);
    checkOutput("abs_disp_comb", bus_if.addr_comb, ABS_EXP);
    stepEdge();
    checkOutput("abs_disp_addr", bus_if.addr, ABS_EXP);

    // mod=10 disp32 with wrap-around
    applyStimulus(8'b10_000_000, 1'b0, 32'h0, 32'hFFFFFFF0, 32'h00000020, 16'h0, 1'b1, 3'b000);
    checkOutput("wrap_comb", bus_if.addr_comb, 32'h00000010);

    // rmsel picks dval or sval as base
    applyStimulus(8'b00_000_011, 1'b0, 32'h000000AA, 32'h00000055, 32'h0, 16'h0, 1'b0, 3'b000);
    checkOutput("base_sval", bus_if.addr_comb, 32'h00000055);
    applyStimulus(8'b00_000_011, 1'b1, 32'h000000AA, 32'h00000055, 32'h0, 16'h0, 1'b0, 3'b000);
    checkOutput("base_dval", bus_if.addr_comb, 32'h000000AA);

    // mod=11 register operand: no address, no access
    applyStimulus(8'b11_000_000, 1'b1, 32'h12340000, 32'h0, 32'h00000040, 16'h0, 1'b1, 3'b100);
    checkOutput("reg_comb", bus_if.addr_comb, 32'h0);
    stepEdge();
    checkOutput("reg_addr", bus_if.addr, 32'h0);
    checkOutput("reg_mem_acc", {31'b0, bus_if.mem_acc}, 32'h0);

    // Jump with no read still needs memory
    applyStimulus(8'b00_000_000, 1'b1, 32'hCAFE0000, 32'h0, 32'h0, 16'h0, 1'b0, 3'b100);
    stepEdge();
    checkOutput("jmp_addr", bus_if.addr, 32'hCAFE0000);
    checkOutput("jmp_mem_acc", {31'b0, bus_if.mem_acc}, 32'h1);

    // v_in=0 still loads the address
    bus_if.v_in = 1'b0;
    applyStimulus(8'b10_000_000, 1'b1, 32'h00002000, 32'h0, 32'h00000300, 16'h0, 1'b0, 3'b000);
    stepEdge();
    checkOutput("invalid_addr", bus_if.addr, 32'h00002300);
    checkOutput("invalid_v_out", {31'b0, bus_if.v_out}, 32'h0);
    checkOutput("invalid_mem_acc", {31'b0, bus_if.mem_acc}, 32'h0);

    // Load a value, then stall for 3 cycles with changing inputs
    bus_if.v_in = 1'b1;
    applyStimulus(8'b01_000_000, 1'b1, 32'h00004000, 32'h0, 32'h00000010, 16'h0, 1'b1, 3'b000);
    stepEdge();
    checkOutput("pre_stall_addr", bus_if.addr, 32'h00004010);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus_if.e    = 1'b0;
      bus_if.v_in = 1'b0;
      applyStimulus(8'b11_000_000, 1'b0, 32'h0, 32'h11110000 + i, 32'h0, 16'h0, 1'b0, 3'b000);
      stepEdge();
      checkOutput($sformatf("stall_addr_%0d", i), bus_if.addr, 32'h00004010);
      checkOutput($sformatf("stall_mem_acc_%0d", i), {31'b0, bus_if.mem_acc}, 32'h1);
      checkOutput($sformatf("stall_v_out_%0d", i), {31'b0, bus_if.v_out}, 32'h1);
    end

    // Asynchronous reset between clock edges, then reset overriding a load
    @(negedge clk);
    #2;
    r = 1'b0;
    #1;
    checkOutput("async_rst_addr", bus_if.addr, 32'h0);
    checkOutput("async_rst_v_out", {31'b0, bus_if.v_out}, 32'h0);
    checkOutput("async_rst_mem_acc", {31'b0, bus_if.mem_acc}, 32'h0);
    bus_if.e    = 1'b1;
    bus_if.v_in = 1'b1;
    applyStimulus(8'b00_000_000, 1'b1, 32'h00BEEF00, 32'h0, 32'h0, 16'h0, 1'b1, 3'b000);
    stepEdge();
    checkOutput("rst_over_load_addr", bus_if.addr, 32'h0);
    @(negedge clk);
    r = 1'b1;
    stepEdge();
    checkOutput("first_load_addr", bus_if.addr, 32'h00BEEF00);
    checkOutput("first_load_v_out", {31'b0, bus_if.v_out}, 32'h1);

    $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
